fp_to_int: RTL
==============

# fp_to_int

Pipelined IEEE-754 single-precision to signed 32-bit integer converter with valid/ready handshakes on both sides. It unpacks the packed float format that the floating-point adder produces and returns a two's-complement integer, truncated toward zero. Out-of-range values and NaN saturate to a defined value and raise flags. It sits after the adder in the arithmetic datapath, as the format-decode counterpart of the adder's pack stage.

## Interface
Parameters: none.

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-low
- in_valid  input  1  in_data is valid this cycle
- in_ready  output  1  block can accept in_data this cycle (combinational)
- in_data  input  32  IEEE-754 single: [31] sign, [30:23] exponent, [22:0] fraction
- out_valid  output  1  out_data and flags are valid
- out_ready  input  1  downstream accepts the output this cycle
- out_data  output  32  signed integer result
- out_invalid  output  1  NaN, ±inf or out-of-range input; result is saturated
- out_inexact  output  1  nonzero fraction bits were discarded by truncation

## Operation
- Transfers:
  - An input transfer occurs on an edge where in_valid && in_ready.
  - An output transfer occurs on an edge where out_valid && out_ready.
- Three register stages, each with its own valid bit v1, v2, v3. Stage 3 drives the out_* ports.
- S1 (unpack):
  - Register sign s, exponent e, and 24-bit significand m = {e!=0, fraction}.
  - Classify the input as: nan (e==255, fraction!=0), inf (e==255, fraction==0), or small (e<127; covers zero, subnormals and |x|<1).
- S2 (magnitude):
  - Unbiased exponent u = e-127.
  - small: mag=0; inexact = (e!=0 || fraction!=0).
  - u>=31 (includes inf): overflow, except s=1, e=158, fraction=0, which is exactly -2^31 and is not overflow.
  - 23<=u<=30: mag = m << (u-23); inexact=0.
  - 0<=u<23: mag = m >> (23-u); inexact = OR of the shifted-out bits.
  - mag is 32 bits wide; the -2^31 case yields mag=0x80000000.
- S3 (sign/saturate):
  - nan: out_data=0x80000000, invalid=1, inexact=0.
  - overflow with s=0: 0x7FFFFFFF, invalid=1. Overflow with s=1: 0x80000000, invalid=1. inexact=0 in both cases.
  - Otherwise: out_data = s ? -mag : mag (two's complement, 32-bit wrap; gives 0x80000000 for -2^31); invalid=0.
  - -0.0 yields 0.
- Flow control (full backpressure, no bubbles required):
  - r3 = !v3 || out_ready; r2 = !v2 || r3; r1 = !v1 || r2; in_ready = r1.
  - Stage k loads from stage k-1 when rk is high. Its valid bit takes the upstream valid (in_valid for S1).
  - A stage whose rk is low holds its contents.
- Ordering: strictly in order. No input is dropped or duplicated.

## Timing
- Reset (rst low, asynchronous):
  - v1, v2, v3 = 0.
  - out_data = 0, out_invalid = 0, out_inexact = 0.
  - in_ready reads 1 while out_ready is any value.
- Reset takes effect immediately, including mid-stream. All in-flight data is discarded.
- After rst deasserts, the first transfer can occur on the next rising edge.
- Latency: an input accepted at edge k is presented on out_* after edge k+2, provided no stall.
- Throughput: one conversion per cycle while out_ready stays high.
- Stall:
  - With out_ready low and all stages valid, in_ready=0.
  - At most 3 conversions are buffered.
  - out_data and out flags are stable while out_valid && !out_ready.
- Simultaneous events:
  - With the pipe full, out_ready=1 and in_valid=1 in the same cycle, the pipe shifts and accepts the new input in that cycle.
  - in_data is ignored whenever in_valid is low.

## Test plan
- Basic values, streamed back-to-back with out_ready=1:
  - 0x41600000 (14.0) -> 0x0000000E
  - 0xC0C00000 (-6.0) -> 0xFFFFFFFA
  - 0x41250000 (10.3125) -> 0x0000000A, inexact=1
  - Outputs appear on consecutive cycles, starting 2 edges after the first accept.
- Range limits:
  - 0x4F000000 (2^31) -> 0x7FFFFFFF, invalid=1
  - 0xCF000000 (-2^31) -> 0x80000000, invalid=0
  - 0x4EFFFFFF -> 0x7FFFFF80, invalid=0
- Specials:
  - 0x7FC00000 (NaN) -> 0x80000000, invalid=1
  - 0xFF800000 (-inf) -> 0x80000000, invalid=1
  - 0x80000000 (-0) -> 0, flags 0
  - 0x3F000000 (0.5) -> 0, inexact=1
  - 0x00000001 (subnormal) -> 0, inexact=1
- Backpressure:
  - Hold out_ready=0 and offer 5 inputs: exactly 3 are accepted, then in_ready=0.
  - Raise out_ready: all 5 inputs emerge in order, with out_data held stable during the stall.
- Reset mid-stream:
  - Assert rst between edges with 3 conversions in flight: out_valid and out_data drop to 0 immediately, without waiting for a clock edge.
  - After release, a new input 0x41600000 yields 14 with no stale outputs.

Source files
------------

// File: rtl/fp_to_int.sv
// rtl/fp_to_int.sv - three-stage IEEE-754 single to signed int32 converter, truncating toward zero
module fp_to_int (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_invalid,
    output logic        out_inexact
);

    logic        r1, r2, r3;

    logic        v1_q, s1_q, nan1_q, inf1_q, small1_q;
    logic [7:0]  e1_q;
    logic [23:0] m1_q;

    logic        v2_q, s2_q, nan2_q, ovf2_q, inexact2_q;
    logic [31:0] mag2_q;

    logic        v3_q, invalid3_q, inexact3_q;
    logic [31:0] data3_q;

    logic [31:0] mag_d, data_d, m_ext, lost_mask;
    logic [7:0]  lsh, rsh;
    logic        ovf_d, inexact_d, invalid_d, inexact3_d;

    // Each stage may advance when it is empty or the stage below is moving.
    assign r3       = !v3_q || out_ready;
    assign r2       = !v2_q || r3;
    assign r1       = !v1_q || r2;
    assign in_ready = r1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1_q     <= 1'b0;
            s1_q     <= 1'b0;
            nan1_q   <= 1'b0;
            inf1_q   <= 1'b0;
            small1_q <= 1'b0;
            e1_q     <= '0;
            m1_q     <= '0;
        end else if (r1) begin
            v1_q     <= in_valid;
            s1_q     <= in_data[31];
            e1_q     <= in_data[30:23];
            m1_q     <= {in_data[30:23] != 8'd0, in_data[22:0]};
            nan1_q   <= (in_data[30:23] == 8'hFF) && (in_data[22:0] != 23'd0);
            inf1_q   <= (in_data[30:23] == 8'hFF) && (in_data[22:0] == 23'd0);
            small1_q <= in_data[30:23] < 8'd127;
        end
    end

    // Binary point sits 23 bits up in m, so exponent 150 means an unshifted integer.
    always_comb begin
        mag_d     = '0;
        inexact_d = 1'b0;
        ovf_d     = 1'b0;
        m_ext     = {8'd0, m1_q};
        lsh       = e1_q - 8'd150;
        rsh       = 8'd150 - e1_q;
        lost_mask = ~(32'hFFFF_FFFF << rsh[4:0]);
        if (nan1_q) begin
            mag_d = '0;
        end else if (small1_q) begin
            inexact_d = (e1_q != 8'd0) || (m1_q[22:0] != 23'd0);
        end else if (e1_q >= 8'd158) begin
            ovf_d = inf1_q || !(s1_q && (e1_q == 8'd158) && (m1_q[22:0] == 23'd0));
            if (!ovf_d) begin
                mag_d = 32'h8000_0000;
            end
        end else if (e1_q >= 8'd150) begin
            mag_d = m_ext << lsh[3:0];
        end else begin
            mag_d     = m_ext >> rsh[4:0];
            inexact_d = |(m_ext & lost_mask);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v2_q       <= 1'b0;
            s2_q       <= 1'b0;
            nan2_q     <= 1'b0;
            ovf2_q     <= 1'b0;
            inexact2_q <= 1'b0;
            mag2_q     <= '0;
        end else if (r2) begin
            v2_q       <= v1_q;
            s2_q       <= s1_q;
            nan2_q     <= nan1_q;
            ovf2_q     <= ovf_d;
            inexact2_q <= inexact_d;
            mag2_q     <= mag_d;
        end
    end

    always_comb begin
        data_d     = s2_q ? (32'd0 - mag2_q) : mag2_q;
        invalid_d  = 1'b0;
        inexact3_d = inexact2_q;
        if (nan2_q) begin
            data_d     = 32'h8000_0000;
            invalid_d  = 1'b1;
            inexact3_d = 1'b0;
        end else if (ovf2_q) begin
            data_d     = s2_q ? 32'h8000_0000 : 32'h7FFF_FFFF;
            invalid_d  = 1'b1;
            inexact3_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v3_q       <= 1'b0;
            data3_q    <= '0;
            invalid3_q <= 1'b0;
            inexact3_q <= 1'b0;
        end else if (r3) begin
            v3_q       <= v2_q;
            data3_q    <= data_d;
            invalid3_q <= invalid_d;
            inexact3_q <= inexact3_d;
        end
    end

    assign out_valid   = v3_q;
    assign out_data    = data3_q;
    assign out_invalid = invalid3_q;
    assign out_inexact = inexact3_q;

endmodule
